// File: rtl/a2d_sched_pkg.sv
// a2d_sched_pkg: shared types, default channels and command builder for a2d_sched
package a2d_sched_pkg;
  localparam int RES_W = 12;
  localparam logic [2:0] CH_LFT_D = 3'd0;
  localparam logic [2:0] CH_RGHT_D = 3'd4;
  localparam logic [2:0] CH_STEER_D = 3'd5;
  localparam logic [2:0] CH_BATT_D = 3'd6;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD = 3'd1,
    WAIT1 = 3'd2,
    GAP = 3'd3,
    READ = 3'd4,
    WAIT2 = 3'd5
  } state_t;
  typedef logic [1:0] idx_t;
  function automatic logic [15:0] build_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction
endpackage

// File: rtl/a2d_sched_load_avg.sv
// load_avg: two-sample 12-bit averager with a 13-bit sum so nothing overflows
module load_avg
  import a2d_sched_pkg::*;
(
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  output logic [RES_W-1:0] avg
);
  logic [RES_W:0] sum;
  // widen before adding so the carry survives the halving
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    avg = sum[RES_W:1];
  end
endmodule

// File: rtl/a2d_sched.sv
// a2d_sched: round-robin A2D conversion scheduler; LOAD_AVG_EN averages the load cells
module a2d_sched
  import a2d_sched_pkg::*;
#(
  parameter logic [2:0] CH_LFT = CH_LFT_D,
  parameter logic [2:0] CH_RGHT = CH_RGHT_D,
  parameter logic [2:0] CH_STEER = CH_STEER_D,
  parameter logic [2:0] CH_BATT = CH_BATT_D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_load,
  output logic [11:0] rght_load,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        upd,
  output logic        busy
);
  state_t state, nxt_state;
  idx_t idx;
  logic [2:0] ch;
  logic [11:0] res, lft_new, rght_new;
  logic unused_hi;
  assign unused_hi = ^rd_data[15:12];
  assign res = rd_data[11:0];
`ifdef LOAD_AVG_EN
  load_avg u_lft_avg (.a(lft_load), .b(res), .avg(lft_new));
  load_avg u_rght_avg (.a(rght_load), .b(res), .avg(rght_new));
`else
  assign lft_new = res;
  assign rght_new = res;
`endif
  // channel and command follow the index, which only moves at the end of a conversion
  always_comb begin
    ch = idx == 2'd0 ? CH_LFT : idx == 2'd1 ? CH_RGHT : idx == 2'd2 ? CH_STEER : CH_BATT;
    cmd = build_cmd(ch);
    wrt = !rst && (state == CMD || state == READ);
    upd = !rst && state == WAIT2 && done;
    busy = state != IDLE;
  end
  // next-state decode; done is only honoured in the two wait states
  always_comb begin
    nxt_state = IDLE;
    case (state)
      IDLE: nxt_state = nxt ? CMD : IDLE;
      CMD: nxt_state = WAIT1;
      WAIT1: nxt_state = done ? GAP : WAIT1;
      GAP: nxt_state = READ;
      READ: nxt_state = WAIT2;
      WAIT2: nxt_state = done ? IDLE : WAIT2;
      default: nxt_state = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt_state;
  end
  // result capture and round-robin advance on upd
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      lft_load <= '0;
      rght_load <= '0;
      steer_pot <= '0;
      batt <= '0;
    end else if (upd) begin
      idx <= idx + 2'd1;
      lft_load <= idx == 2'd0 ? lft_new : lft_load;
      rght_load <= idx == 2'd1 ? rght_new : rght_load;
      steer_pot <= idx == 2'd2 ? res : steer_pot;
      batt <= idx == 2'd3 ? res : batt;
    end
  end
endmodule

// File: tb/tb_a2d_sched.sv
// tb_a2d_sched: randomized directed checks of a2d_sched against a conversion-level model
module tb_a2d_sched;
  logic clk = 1'b0, rst = 1'b1, nxt = 1'b0, done = 1'b0;
  logic [15:0] rd_data = '0;
  logic wrt, upd, busy;
  logic [15:0] cmd;
  logic [11:0] lft_load, rght_load, steer_pot, batt;
  int checks = 0, errors = 0;
  int wrt_cnt = 0, upd_cnt = 0;
  int midx = 0;
  int mres [4];
  int chans [4] = '{0, 4, 5, 6};
  a2d_sched dut (
    .clk(clk), .rst(rst), .nxt(nxt), .wrt(wrt), .cmd(cmd), .done(done), .rd_data(rd_data),
    .lft_load(lft_load), .rght_load(rght_load), .steer_pot(steer_pot), .batt(batt),
    .upd(upd), .busy(busy)
  );
  always #10 clk = ~clk;
  always @(posedge clk) begin
    if (wrt === 1'b1) wrt_cnt++;
    if (upd === 1'b1) upd_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_regs(input string tag);
    chk({tag, "_lft"}, {20'h0, lft_load}, mres[0]);
    chk({tag, "_rght"}, {20'h0, rght_load}, mres[1]);
    chk({tag, "_steer"}, {20'h0, steer_pot}, mres[2]);
    chk({tag, "_batt"}, {20'h0, batt}, mres[3]);
  endtask
  task automatic model_reset();
    midx = 0;
    foreach (mres[i]) mres[i] = 0;
  endtask
  task automatic model_update(input int v);
`ifdef LOAD_AVG_EN
    mres[midx] = midx < 2 ? (mres[midx] + v) / 2 : v;
`else
    mres[midx] = v;
`endif
    midx = (midx + 1) % 4;
  endtask
  task automatic conv(input logic [15:0] data, input int d1, input int d2, input bit hold, input bit spur);
    int w0, u0;
    logic [15:0] ecmd;
    ecmd = {2'b00, 3'(chans[midx]), 11'h000};
    w0 = wrt_cnt;
    u0 = upd_cnt;
    rd_data = data;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    nxt = 1'b1;
    @(negedge clk);
    nxt = hold;
    chk("cmd_wrt", wrt, 1);
    chk("cmd_word", cmd, ecmd);
    chk("cmd_busy", busy, 1);
    repeat (d1) @(negedge clk);
    chk("wait1_wrt", wrt, 0);
    done = 1'b1;
    #1 chk("wait1_upd", upd, 0);
    @(negedge clk);
    done = spur;
    chk("gap_wrt", wrt, 0);
    @(negedge clk);
    done = 1'b0;
    chk("read_wrt", wrt, 1);
    chk("read_word", cmd, ecmd);
    repeat (d2) @(negedge clk);
    done = 1'b1;
    nxt = 1'b0;
    #1 chk("wait2_upd", upd, 1);
    @(negedge clk);
    done = 1'b0;
    model_update(int'(data[11:0]));
    chk_regs("res");
    chk("end_busy", busy, 0);
    chk("end_upd", upd, 0);
    chk("wrt_pulses", wrt_cnt - w0, 2);
    chk("upd_pulses", upd_cnt - u0, 1);
  endtask
  task automatic do_reset();
    int u0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    chk("rst_busy", busy, 0);
    chk("rst_wrt", wrt, 0);
    chk("rst_cmd", cmd, 16'h0000);
    chk_regs("rst");
    u0 = upd_cnt;
    rst = 1'b0;
    done = 1'b1;
    #1 chk("rst_done_upd", upd, 0);
    @(negedge clk);
    done = 1'b0;
    chk("rst_done_busy", busy, 0);
    chk("rst_done_cnt", upd_cnt - u0, 0);
  endtask
  initial begin
    int u0;
    model_reset();
    do_reset();
    conv(16'h0ABC, 20, 20, 1'b0, 1'b0);
    do_reset();
    conv(16'h0111, 3, 2, 1'b0, 1'b0);
    conv(16'h0222, 1, 4, 1'b0, 1'b0);
    conv(16'h0333, 2, 1, 1'b0, 1'b0);
    conv(16'h0444, 5, 3, 1'b0, 1'b0);
    conv(16'(($urandom & 32'hFFFF)), 2, 2, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      conv(16'($urandom), $urandom_range(1, 6), $urandom_range(1, 6), 1'($urandom), 1'($urandom));
    @(negedge clk);
    nxt = 1'b1;
    repeat (3) @(negedge clk);
    nxt = 1'b0;
    repeat (2) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    u0 = upd_cnt;
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    done = 1'b1;
    chk("w2rst_busy", busy, 0);
    chk_regs("w2rst");
    #1 chk("w2rst_upd", upd, 0);
    @(negedge clk);
    done = 1'b0;
    chk("w2rst_cnt", upd_cnt - u0, 0);
    chk("w2rst_idle", busy, 0);
    conv(16'h0FFF, 2, 2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) conv(16'($urandom), 1, 1, 1'b0, 1'b0);
    conv(16'h0001, 2, 3, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/a2d_sched.md
A2D_SCHED -- requirements
Module: a2d_sched

Interface
REQ-001 Parameter CH_LFT, 3'd0, A2D channel of left load cell.
REQ-002 Parameter CH_RGHT, 3'd4, A2D channel of right load cell.
REQ-003 Parameter CH_STEER, 3'd5, A2D channel of steering pot.
REQ-004 Parameter CH_BATT, 3'd6, A2D channel of battery divider.
REQ-005 clk  input  1  system clock (50MHz); the block SHALL use this one clock only, rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 nxt  input  1  request one conversion of the current round-robin channel.
REQ-008 wrt  output  1  one-cycle start pulse to SPI master.
REQ-009 cmd  output  16  SPI command word.
REQ-010 done  input  1  SPI master transaction-complete pulse.
REQ-011 rd_data  input  16  SPI read word; bits [11:0] are the result.
REQ-012 lft_load, rght_load, steer_pot, batt  output  12 each  latest channel results.
REQ-013 upd  output  1  one-cycle pulse when a result register is written.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, CMD, WAIT1, GAP, READ, WAIT2.
REQ-016 Round-robin index SHALL be a 2-bit counter selecting LFT, RGHT, STEER, BATT in order 0..3.
REQ-017 cmd SHALL equal {2'b00, channel[2:0], 11'h000} for the current index, stable from CMD until return to IDLE.
REQ-018 IDLE, nxt=1: go to CMD; nxt=0: stay.
REQ-019 CMD: wrt=1 for exactly that cycle; next state WAIT1.
REQ-020 WAIT1: on done go to GAP, else stay; no wrt.
REQ-021 GAP: one idle cycle; next state READ.
REQ-022 READ: wrt=1 for exactly that cycle, same cmd; next state WAIT2.
REQ-023 WAIT2: on done capture rd_data[11:0] into the indexed result register, assert upd the same cycle, increment index (3 wraps to 0), go to IDLE.
REQ-024 nxt outside IDLE SHALL be ignored (not queued).
REQ-025 done in IDLE, CMD, GAP or READ SHALL be ignored.
REQ-026 nxt and done together in IDLE: nxt taken, done ignored.
REQ-027 Minimum request-to-upd latency SHALL be 5 cycles plus both SPI transaction durations; results become visible the cycle after upd.
REQ-028 Unselected result registers SHALL hold their values.
REQ-029 Unreachable state encodings SHALL transition to IDLE with all pulses low.

Reset
REQ-030 rst=1 at any clock edge, including mid-transaction, SHALL force IDLE, index 0, wrt=0, upd=0, busy=0, all result registers 12'h000, cmd 16'h0000.
REQ-031 A done arriving the cycle after reset release SHALL be ignored.

Configuration
REQ-032 Macro LOAD_AVG_EN defined: lft_load/rght_load SHALL update to (old + new) >> 1 using a 13-bit intermediate, no overflow.
REQ-033 LOAD_AVG_EN undefined: lft_load/rght_load SHALL take rd_data[11:0] directly.
REQ-034 steer_pot and batt SHALL never be averaged.

Structure
REQ-035 Package a2d_sched_pkg SHALL hold the state enum type, the 2-bit index type, default channel constants and a command-word builder function.
REQ-036 One sub-module, load_avg (12-bit two-sample averager), SHALL be instantiated only under LOAD_AVG_EN.
REQ-037 All other logic SHALL reside in a2d_sched.

Verification
REQ-038 Reset, one nxt, done 20 cycles after each wrt, rd_data=16'h0ABC -> cmd=16'h0000 at both wrt pulses, lft_load=12'hABC, upd one cycle, busy falls.
REQ-039 Four back-to-back requests with rd_data 12'h111/12'h222/12'h333/12'h444 -> lft/rght/steer/batt hold those values, cmd channels 0,4,5,6; fifth request uses channel 0 again.
REQ-040 nxt held high during a transaction plus spurious done in GAP -> exactly two wrt pulses per conversion, no extra upd.
REQ-041 rst asserted in WAIT2 before done -> next cycle IDLE, registers 0, following done yields no upd.
REQ-042 LOAD_AVG_EN, lft results 12'hFFF then 12'h001 -> lft_load 12'h7FF then 12'h400; without macro 12'hFFF then 12'h001.
